// File: rtl/frog_jump_render_pkg.sv
// frog_pkg: shared FSM state type, palette and default geometry for the frog jump renderer
package frog_pkg;
    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_FROG   = 12'h0F0;
    localparam logic [11:0] C_GROUND = 12'h840;
    localparam logic [11:0] C_SKY    = 12'h4AF;
    localparam int D_FROG_X   = 304;
    localparam int D_FROG_W   = 32;
    localparam int D_FROG_H   = 32;
    localparam int D_GROUND_Y = 400;
    localparam int D_JUMP_H   = 96;
    localparam int D_STEP     = 4;
endpackage

// File: rtl/frog_jump_render_if.sv
// frog_jump_render_if: pixel/frame/button inputs and colour/status outputs of the renderer
//   master: drives pix_x, pix_y, pix_v, frame_id, jump_btn; reads rgb, rgb_v, frog_top, airborne
//   slave : the renderer side
interface frog_jump_render_if #(
    parameter int pA = 10,
    parameter int fA = 32
);
    logic [pA-1:0] pix_x;
    logic [pA-1:0] pix_y;
    logic          pix_v;
    logic [fA-1:0] frame_id;
    logic          jump_btn;
    logic [11:0]   rgb;
    logic          rgb_v;
    logic [pA-1:0] frog_top;
    logic          airborne;
    modport master (output pix_x, pix_y, pix_v, frame_id, jump_btn,
                    input  rgb, rgb_v, frog_top, airborne);
    modport slave  (input  pix_x, pix_y, pix_v, frame_id, jump_btn,
                    output rgb, rgb_v, frog_top, airborne);
endinterface

// File: rtl/frog_jump_render_btn_sync.sv
// btn_sync: two-flop synchroniser for the raw jump button plus a rising-edge detector
//   i_btn  : asynchronous button, high = pressed
//   o_edge : one-cycle pulse on each synchronised rising edge
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_edge
);
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end
    assign o_edge = r_s2 & ~r_s3;
endmodule

// File: rtl/frog_jump_render.sv
// frog_jump_render: frame-stepped jump FSM for a frog sprite and a one-cycle-latency pixel renderer
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : slave side of frog_jump_render_if (pixel position/valid, frame id, button in;
//              rgb, rgb_v, frog_top, airborne out)
module frog_jump_render
    import frog_pkg::*;
#(
    parameter int pA       = 10,
    parameter int fA       = 32,
    parameter int FROG_X   = D_FROG_X,
    parameter int FROG_W   = D_FROG_W,
    parameter int FROG_H   = D_FROG_H,
    parameter int GROUND_Y = D_GROUND_Y,
    parameter int JUMP_H   = D_JUMP_H,
    parameter int STEP     = D_STEP
)(
    input logic                clk,
    input logic                rst,
    frog_jump_render_if.slave  bus
);
    localparam logic [pA-1:0] GROUND_TOP = pA'(GROUND_Y - FROG_H);
    localparam logic [pA-1:0] APEX       = pA'(GROUND_Y - FROG_H - JUMP_H);
    localparam logic [pA-1:0] STEP_W     = pA'(STEP);
    localparam logic [pA:0]   STEP_E     = (pA+1)'(STEP);

    logic [fA-1:0] r_frame_q;
    state_t        r_state, w_state_nxt;
    logic [pA-1:0] r_top, w_top_nxt, w_dn, w_up;
    logic          r_pending, w_pending_nxt;
    logic          w_tick, w_edge, w_airborne, w_in_frog;
    logic [pA:0]   w_top_e, w_x, w_y;
    logic [11:0]   r_rgb, w_rgb_nxt;
    logic          r_rgb_v;

    btn_sync u_btn_sync (.clk(clk), .rst(rst), .i_btn(bus.jump_btn), .o_edge(w_edge));

    assign w_tick  = bus.frame_id != r_frame_q;
    assign w_top_e = {1'b0, r_top};
    // widened compares keep the saturation test from wrapping near 0 / the top of the range
    assign w_dn = (w_top_e < {1'b0, APEX} + STEP_E) ? APEX : r_top - STEP_W;
    assign w_up = (w_top_e + STEP_E > {1'b0, GROUND_TOP}) ? GROUND_TOP : r_top + STEP_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_q <= '0;
            r_state   <= IDLE;
            r_top     <= GROUND_TOP;
            r_pending <= 1'b0;
        end else begin
            r_frame_q <= bus.frame_id;
            r_state   <= w_state_nxt;
            r_top     <= w_top_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // every move happens on a frame tick, i.e. during blanking, so sprites never tear
    always_comb begin
        w_state_nxt   = r_state;
        w_top_nxt     = r_top;
        w_pending_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_top_nxt     = GROUND_TOP;
                w_pending_nxt = r_pending | w_edge;
                if (w_tick && (r_pending || w_edge)) begin
                    w_state_nxt   = RISE;
                    w_pending_nxt = 1'b0;
                    w_top_nxt     = w_dn;
                end
            end
            RISE: if (w_tick) begin
                w_state_nxt = (r_top == APEX) ? FALL : RISE;
                w_top_nxt   = w_dn;
            end
            FALL: if (w_tick) begin
                w_state_nxt = (r_top == GROUND_TOP) ? IDLE : FALL;
                w_top_nxt   = w_up;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb w_airborne = (r_state == RISE) || (r_state == FALL);

    assign w_x = {1'b0, bus.pix_x};
    assign w_y = {1'b0, bus.pix_y};
    assign w_in_frog = (w_x >= (pA+1)'(FROG_X)) && (w_x < (pA+1)'(FROG_X + FROG_W)) &&
                       (w_y >= w_top_e) && (w_y < w_top_e + (pA+1)'(FROG_H));
    always_comb w_rgb_nxt = !bus.pix_v ? C_BLACK :
                            w_in_frog ? C_FROG :
                            (w_y >= (pA+1)'(GROUND_Y)) ? C_GROUND : C_SKY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= C_BLACK;
            r_rgb_v <= 1'b0;
        end else begin
            r_rgb   <= w_rgb_nxt;
            r_rgb_v <= bus.pix_v;
        end
    end

    assign bus.rgb      = r_rgb;
    assign bus.rgb_v    = r_rgb_v;
    assign bus.frog_top = r_top;
    assign bus.airborne = w_airborne;
endmodule

// File: doc/frog_jump_render.md
FROG_JUMP_RENDER -- requirements
Module: frog_jump_render

Interface
REQ-001 Parameter pA, default 10, pixel coordinate width; SHALL match the upstream VGA controller.
REQ-002 Parameter fA, default 32, frame counter width.
REQ-003 Parameters FROG_X=304, FROG_W=32, FROG_H=32, GROUND_Y=400, JUMP_H=96, STEP=4; geometry in pixels.
REQ-004 clk  input  1  pixel clock, shared with the VGA controller.
REQ-005 rst  input  1  reset; one clock, asynchronous, active-high.
REQ-006 pix_x  input  pA  current pixel column from the VGA controller.
REQ-007 pix_y  input  pA  current pixel row from the VGA controller.
REQ-008 pix_v  input  1  pixel is in the visible area.
REQ-009 frame_id  input  fA  frame counter from the VGA controller.
REQ-010 jump_btn  input  1  raw asynchronous push-button, high = pressed.
REQ-011 rgb  output  12  pixel colour {R4,G4,B4}, registered.
REQ-012 rgb_v  output  1  rgb is valid (pix_v delayed by one cycle).
REQ-013 frog_top  output  pA  current top row of the frog sprite.
REQ-014 airborne  output  1  high while the FSM is in RISE or FALL.

Function
REQ-015 frame_tick SHALL pulse for exactly one cycle when frame_id differs from its value registered on the previous cycle.
REQ-016 jump_btn SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal SHALL set the pending flag.
REQ-017 The FSM SHALL have the states IDLE, RISE and FALL; all transitions and frog_top updates SHALL occur only on frame_tick.
REQ-018 IDLE: frog_top = GROUND_Y-FROG_H; on a tick with pending (or a coincident edge) set, the FSM SHALL go to RISE and clear pending.
REQ-019 RISE: each tick SHALL do frog_top -= STEP, saturating at APEX = GROUND_Y-FROG_H-JUMP_H; a tick that finds frog_top == APEX SHALL go to FALL.
REQ-020 FALL: each tick SHALL do frog_top += STEP, saturating at GROUND_Y-FROG_H; a tick that finds frog_top at ground SHALL go to IDLE.
REQ-021 Button edges while airborne SHALL be discarded; pending SHALL stay 0 outside IDLE.
REQ-022 Rendering SHALL have a latency of 1 cycle; priority: pix_v=0 -> 12'h000; frog box -> 12'h0F0; pix_y >= GROUND_Y -> 12'h840; otherwise sky 12'h4AF.
REQ-023 Frog box: FROG_X <= pix_x < FROG_X+FROG_W and frog_top <= pix_y < frog_top+FROG_H; comparisons SHALL use pA+1 bits so the sums cannot wrap.
REQ-024 frog_top changes only at a frame boundary (blanking), so no frame SHALL show a torn sprite.

Reset
REQ-025 On rst: rgb=0, rgb_v=0, FSM=IDLE, frog_top=GROUND_Y-FROG_H, airborne=0, pending=0, synchroniser flops=0, stored frame_id=0.
REQ-026 rst asserted mid-jump SHALL return the frog to ground immediately, with no pending jump kept.

Structure
REQ-027 Package frog_pkg SHALL hold the state enum (IDLE/RISE/FALL), the colour constants and the geometry defaults.
REQ-028 Sub-module btn_sync SHALL contain the synchroniser and the rising-edge detector; it outputs a 1-cycle edge pulse.

Verification
REQ-029 Reset released, no press, 3 frames -> frog_top=368, airborne=0; pixel (310,380) gives 12'h0F0 one cycle later; pixel (0,420) gives 12'h840; pixel (0,10) gives 12'h4AF.
REQ-030 Single press while IDLE -> at the next tick frog_top=364 (RISE); it reaches 272 after 24 ticks, descends to 368 after 24 more, then IDLE.
REQ-031 Second press during RISE -> ignored; after landing the FSM stays IDLE and pending=0.
REQ-032 Press edge in the same cycle as frame_tick while IDLE -> jump starts on that tick.
REQ-033 rst asserted at frog_top=300 during FALL -> frog_top=368, state IDLE, rgb=0 asynchronously.
REQ-034 pix_v low at pix_x=310, pix_y=380 -> rgb=12'h000 and rgb_v=0 on the next cycle.
